// File: rtl/iir_smoother_if.sv
// Sample stream into the IIR smoother and its filtered output stream.
// The producer of x uses the master modport; the filter uses the slave modport.
interface iir_smoother_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] x;
  logic [2:0]    k;
  logic [DW-1:0] y;
  logic          out_valid;
  logic          settled;

  modport master (
    output in_valid, x, k,
    input  y, out_valid, settled
  );

  modport slave (
    input  in_valid, x, k,
    output y, out_valid, settled
  );
endinterface

// File: rtl/iir_smoother.sv
// First-order leaky-integrator low-pass stage behind the FIR smoother.
// Primes on the first sample, then blends each new sample in by 2^-k.
module iir_smoother #(
  parameter int DW         = 8,
  parameter int FRAC       = 4,
  parameter int SETTLE_TOL = 2,
  parameter int SETTLE_CNT = 16
) (
  input  logic          clk,
  input  logic          reset,
  iir_smoother_if.slave bus
);
  localparam int AW = DW + FRAC;
  localparam int CW = $clog2(SETTLE_CNT + 1);
  localparam logic [DW-1:0] TOL      = DW'(SETTLE_TOL);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CNT);
  localparam logic [AW-1:0] HALF_LSB = AW'(1) << (FRAC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_acc, w_acc_next;
  logic [DW-1:0] r_y, w_y_next;
  logic          r_out_valid, w_out_valid_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_settled, w_settled_next;

  // Blend datapath: acc_new always lies between acc and x<<FRAC, so truncation is safe.
  logic [AW-1:0]        w_x_scaled;
  logic signed [AW:0]   w_diff;
  logic signed [AW:0]   w_step;
  logic [AW:0]          w_sum;
  logic [AW-1:0]        w_acc_blend;
  logic [AW-1:0]        w_round;
  logic [DW-1:0]        w_y_blend;
  logic [DW-1:0]        w_err;
  logic                 w_in_tol;
  logic                 w_unused;

  assign w_x_scaled  = {bus.x, {FRAC{1'b0}}};
  assign w_diff      = $signed({1'b0, w_x_scaled}) - $signed({1'b0, r_acc});
  assign w_step      = w_diff >>> bus.k;
  assign w_sum       = {1'b0, r_acc} + $unsigned(w_step);
  assign w_acc_blend = w_sum[AW-1:0];
  assign w_round     = w_acc_blend + HALF_LSB;
  assign w_y_blend   = w_round[AW-1:FRAC];
  assign w_err       = (bus.x >= w_y_blend) ? (bus.x - w_y_blend) : (w_y_blend - bus.x);
  assign w_in_tol    = (w_err <= TOL);
  assign w_unused    = ^{w_sum[AW], w_round[FRAC-1:0]};

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_y_next         = r_y;
    w_out_valid_next = 1'b0;
    w_cnt_next       = r_cnt;
    w_settled_next   = r_settled;
    if (bus.in_valid) begin
      w_out_valid_next = 1'b1;
      case (r_state)
        IDLE: begin
          w_state_next   = RUN;
          w_acc_next     = w_x_scaled;
          w_y_next       = bus.x;
          w_cnt_next     = CW'(1);
          w_settled_next = (CW'(1) >= CNT_MAX);
        end
        RUN: begin
          w_acc_next = w_acc_blend;
          w_y_next   = w_y_blend;
          if (!w_in_tol)              w_cnt_next = '0;
          else if (r_cnt != CNT_MAX)  w_cnt_next = r_cnt + CW'(1);
          w_settled_next = (w_cnt_next >= CNT_MAX);
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_settled   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_y         <= w_y_next;
      r_out_valid <= w_out_valid_next;
      r_cnt       <= w_cnt_next;
      r_settled   <= w_settled_next;
    end
  end

  assign bus.y         = r_y;
  assign bus.out_valid = r_out_valid;
  assign bus.settled   = r_settled;
endmodule
